// File: rtl/lbus_tx_frame_monitor.sv
// Passive frame checker and statistics collector for the 8-segment 400G LBUS TX bus.
// Segments of a beat are walked in order 0..NSEG-1; all results land in one register stage.
module lbus_tx_frame_monitor #(
  parameter int MIN_FRAME_BYTES = 60,
  parameter int MAX_FRAME_BYTES = 9600,
  parameter int NSEG            = 8
) (
  input  logic                lbus_txclk,
  input  logic                lbus_txresetn,
  input  logic                lbus_tx_rdy,
  input  logic [128*NSEG-1:0] lbus_txdata,
  input  logic [NSEG-1:0]     lbus_txena,
  input  logic [NSEG-1:0]     lbus_txsop,
  input  logic [NSEG-1:0]     lbus_txeop,
  input  logic [NSEG-1:0]     lbus_txerr,
  input  logic [4*NSEG-1:0]   lbus_txmty,
  input  logic                counters_reset,
  output logic [31:0]         frame_count,
  output logic [47:0]         byte_count,
  output logic [31:0]         err_frame_count,
  output logic [15:0]         runt_count,
  output logic [15:0]         oversize_count,
  output logic [15:0]         framing_error_count,
  output logic [31:0]         stall_cycle_count,
  output logic [3:0]          framing_error_flags,
  output logic [15:0]         last_frame_len,
  output logic                last_frame_len_valid
);

  localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME_BYTES);
  localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME_BYTES);

  typedef enum logic {IDLE, INFRAME} state_t;

  state_t      state_reg, state_next;
  logic [15:0] len_reg, len_next;

  logic [4:0]      seg_bytes [NSEG];
  logic [NSEG-1:0] mty_nz;
  logic [NSEG-1:0] ena_gap;

  logic [3:0]  viol;
  logic [3:0]  n_comp, n_err, n_runt, n_over;
  logic [7:0]  beat_bytes;
  logic [15:0] last_len;
  logic        last_valid;
  logic [16:0] len_sum;
  logic        accept;

  // Payload is never inspected; folded so the port is visibly consumed.
  logic unused_data;
  assign unused_data = ^lbus_txdata;

  // A non-zero mty on a non-eop segment is a violation and the segment counts as full.
  genvar gi;
  generate
    for (gi = 0; gi < NSEG; gi++) begin : g_seg
      assign mty_nz[gi]    = |lbus_txmty[4*gi +: 4];
      assign seg_bytes[gi] = (mty_nz[gi] && !lbus_txeop[gi]) ? 5'd16
                           : 5'd16 - {1'b0, lbus_txmty[4*gi +: 4]};
    end
  endgenerate

  assign ena_gap = lbus_txena & ~{lbus_txena[NSEG-2:0], 1'b1};

  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    viol       = 4'd0;
    n_comp     = 4'd0;
    n_err      = 4'd0;
    n_runt     = 4'd0;
    n_over     = 4'd0;
    beat_bytes = 8'd0;
    last_len   = 16'd0;
    last_valid = 1'b0;
    len_sum    = 17'd0;
    accept     = 1'b0;
    if (|lbus_txena) begin
      viol[0] = |ena_gap;
      viol[3] = |(lbus_txena & mty_nz & ~lbus_txeop);
      for (int i = 0; i < NSEG; i++) begin
        if (lbus_txena[i]) begin
          accept = 1'b1;
          if (lbus_txsop[i]) begin
            if (state_next == INFRAME) viol[1] = 1'b1;
            len_next = {11'd0, seg_bytes[i]};
          end else if (state_next == IDLE) begin
            viol[2] = 1'b1;
            accept  = 1'b0;
          end else begin
            len_sum  = {1'b0, len_next} + {12'd0, seg_bytes[i]};
            len_next = len_sum[16] ? 16'hFFFF : len_sum[15:0];
          end
          if (accept) begin
            beat_bytes = beat_bytes + {3'd0, seg_bytes[i]};
            if (lbus_txeop[i]) begin
              n_comp     = n_comp + 4'd1;
              n_err      = n_err + {3'd0, lbus_txerr[i]};
              n_runt     = n_runt + {3'd0, (len_next < MIN_LEN)};
              n_over     = n_over + {3'd0, (len_next > MAX_LEN)};
              last_len   = len_next;
              last_valid = 1'b1;
              state_next = IDLE;
            end else begin
              state_next = INFRAME;
            end
          end
        end
      end
    end
  end

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [3:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {13'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  always_ff @(posedge lbus_txclk or negedge lbus_txresetn) begin
    if (!lbus_txresetn) begin
      state_reg            <= IDLE;
      len_reg              <= 16'd0;
      frame_count          <= 32'd0;
      byte_count           <= 48'd0;
      err_frame_count      <= 32'd0;
      runt_count           <= 16'd0;
      oversize_count       <= 16'd0;
      framing_error_count  <= 16'd0;
      stall_cycle_count    <= 32'd0;
      framing_error_flags  <= 4'd0;
      last_frame_len       <= 16'd0;
      last_frame_len_valid <= 1'b0;
    end else begin
      // Frame tracking keeps running through a counter clear.
      state_reg <= state_next;
      len_reg   <= len_next;
      if (counters_reset) begin
        frame_count          <= 32'd0;
        byte_count           <= 48'd0;
        err_frame_count      <= 32'd0;
        runt_count           <= 16'd0;
        oversize_count       <= 16'd0;
        framing_error_count  <= 16'd0;
        stall_cycle_count    <= 32'd0;
        framing_error_flags  <= 4'd0;
        last_frame_len       <= 16'd0;
        last_frame_len_valid <= 1'b0;
      end else begin
        frame_count          <= frame_count + {28'd0, n_comp};
        byte_count           <= byte_count + {40'd0, beat_bytes};
        err_frame_count      <= err_frame_count + {28'd0, n_err};
        runt_count           <= sat_add(runt_count, n_runt);
        oversize_count       <= sat_add(oversize_count, n_over);
        framing_error_count  <= sat_add(framing_error_count, {3'd0, |viol});
        stall_cycle_count    <= stall_cycle_count + {31'd0, ~lbus_tx_rdy};
        framing_error_flags  <= framing_error_flags | viol;
        last_frame_len_valid <= last_valid;
        if (last_valid) last_frame_len <= last_len;
      end
    end
  end

endmodule

// File: tb/tb_lbus_tx_frame_monitor.sv
// Directed self-checking bench for lbus_tx_frame_monitor; each task drives one scenario and checks inline.
module tb_lbus_tx_frame_monitor;

  logic          clk;
  logic          rst_n;
  logic          rdy;
  logic [1023:0] data;
  logic [7:0]    ena, sop, eop, err;
  logic [31:0]   mty;
  logic          clr;
  logic [31:0]   frame_count, err_frame_count, stall_cycle_count;
  logic [47:0]   byte_count;
  logic [15:0]   runt_count, oversize_count, framing_error_count, last_frame_len;
  logic [3:0]    framing_error_flags;
  logic          last_frame_len_valid;

  int total = 0;
  int bad   = 0;

  lbus_tx_frame_monitor dut (
    .lbus_txclk           (clk),
    .lbus_txresetn        (rst_n),
    .lbus_tx_rdy          (rdy),
    .lbus_txdata          (data),
    .lbus_txena           (ena),
    .lbus_txsop           (sop),
    .lbus_txeop           (eop),
    .lbus_txerr           (err),
    .lbus_txmty           (mty),
    .counters_reset       (clr),
    .frame_count          (frame_count),
    .byte_count           (byte_count),
    .err_frame_count      (err_frame_count),
    .runt_count           (runt_count),
    .oversize_count       (oversize_count),
    .framing_error_count  (framing_error_count),
    .stall_cycle_count    (stall_cycle_count),
    .framing_error_flags  (framing_error_flags),
    .last_frame_len       (last_frame_len),
    .last_frame_len_valid (last_frame_len_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One beat: drive, capture at the next edge, sample 1 time unit later, return to idle.
  task automatic beat(input logic [7:0] b_ena, input logic [7:0] b_sop, input logic [7:0] b_eop,
                      input logic [7:0] b_err, input logic [31:0] b_mty, input logic b_rdy,
                      input logic b_clr);
    ena = b_ena; sop = b_sop; eop = b_eop; err = b_err; mty = b_mty; rdy = b_rdy; clr = b_clr;
    data = {32{$urandom}};
    @(posedge clk);
    #1;
    ena = 8'd0; sop = 8'd0; eop = 8'd0; err = 8'd0; mty = 32'd0; rdy = 1'b1; clr = 1'b0;
  endtask

  task automatic clear_counters();
    beat(8'h00, 8'h00, 8'h00, 8'h00, 32'd0, 1'b1, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    total++; if (frame_count !== 32'd0) begin bad++; $display("FAIL reset_frames got=%0d exp=0", frame_count); end
    total++; if (byte_count !== 48'd0) begin bad++; $display("FAIL reset_bytes got=%0d exp=0", byte_count); end
    total++; if (framing_error_flags !== 4'd0) begin bad++; $display("FAIL reset_flags got=%b exp=0000", framing_error_flags); end
    total++; if (last_frame_len_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", last_frame_len_valid); end
    rst_n = 1'b1;
    beat(8'h00, 8'h00, 8'h00, 8'h00, 32'd0, 1'b1, 1'b0);
    total++; if (stall_cycle_count !== 32'd0) begin bad++; $display("FAIL reset_stall got=%0d exp=0", stall_cycle_count); end
    $display("test_reset done");
  endtask

  task automatic test_long_frame();
    clear_counters();
    for (int b = 0; b < 64; b++) begin
      beat(8'hFF, (b == 0) ? 8'h01 : 8'h00, (b == 63) ? 8'h80 : 8'h00, 8'h00, 32'd0, 1'b1, 1'b0);
      if (b == 0) begin
        total++; if (byte_count !== 48'd128) begin bad++; $display("FAIL long_inprogress_bytes got=%0d exp=128", byte_count); end
      end
    end
    total++; if (frame_count !== 32'd1) begin bad++; $display("FAIL long_frames got=%0d exp=1", frame_count); end
    total++; if (byte_count !== 48'd8192) begin bad++; $display("FAIL long_bytes got=%0d exp=8192", byte_count); end
    total++; if (last_frame_len !== 16'd8192) begin bad++; $display("FAIL long_len got=%0d exp=8192", last_frame_len); end
    total++; if (last_frame_len_valid !== 1'b1) begin bad++; $display("FAIL long_valid got=%b exp=1", last_frame_len_valid); end
    total++; if (oversize_count !== 16'd0) begin bad++; $display("FAIL long_oversize got=%0d exp=0", oversize_count); end
    total++; if (framing_error_flags !== 4'd0) begin bad++; $display("FAIL long_flags got=%b exp=0000", framing_error_flags); end
    beat(8'h00, 8'h00, 8'h00, 8'h00, 32'd0, 1'b1, 1'b0);
    total++; if (last_frame_len_valid !== 1'b0) begin bad++; $display("FAIL long_valid_pulse got=%b exp=0", last_frame_len_valid); end
    $display("test_long_frame done");
  endtask

  task automatic test_multi_complete();
    clear_counters();
    beat(8'h07, 8'h03, 8'h05, 8'h00, 32'h0000_0004, 1'b1, 1'b0);
    total++; if (frame_count !== 32'd2) begin bad++; $display("FAIL multi_frames got=%0d exp=2", frame_count); end
    total++; if (last_frame_len !== 16'd32) begin bad++; $display("FAIL multi_len got=%0d exp=32", last_frame_len); end
    total++; if (runt_count !== 16'd2) begin bad++; $display("FAIL multi_runts got=%0d exp=2", runt_count); end
    total++; if (byte_count !== 48'd44) begin bad++; $display("FAIL multi_bytes got=%0d exp=44", byte_count); end
    total++; if (framing_error_flags !== 4'd0) begin bad++; $display("FAIL multi_flags got=%b exp=0000", framing_error_flags); end
    $display("test_multi_complete done");
  endtask

  task automatic test_sop_in_frame();
    clear_counters();
    beat(8'hFF, 8'h01, 8'h00, 8'h00, 32'd0, 1'b1, 1'b0);
    beat(8'hFF, 8'h08, 8'h00, 8'h00, 32'd0, 1'b1, 1'b0);
    total++; if (frame_count !== 32'd0) begin bad++; $display("FAIL abort_frames_mid got=%0d exp=0", frame_count); end
    beat(8'hFF, 8'h00, 8'h80, 8'h00, 32'd0, 1'b1, 1'b0);
    total++; if (framing_error_flags !== 4'b0010) begin bad++; $display("FAIL abort_flags got=%b exp=0010", framing_error_flags); end
    total++; if (framing_error_count !== 16'd1) begin bad++; $display("FAIL abort_errcnt got=%0d exp=1", framing_error_count); end
    total++; if (frame_count !== 32'd1) begin bad++; $display("FAIL abort_frames got=%0d exp=1", frame_count); end
    total++; if (last_frame_len !== 16'd208) begin bad++; $display("FAIL abort_len got=%0d exp=208", last_frame_len); end
    total++; if (byte_count !== 48'd384) begin bad++; $display("FAIL abort_bytes got=%0d exp=384", byte_count); end
    $display("test_sop_in_frame done");
  endtask

  task automatic test_ena_gap();
    clear_counters();
    beat(8'h05, 8'h01, 8'h04, 8'h00, 32'd0, 1'b1, 1'b0);
    total++; if (framing_error_flags !== 4'b0001) begin bad++; $display("FAIL gap_flags got=%b exp=0001", framing_error_flags); end
    total++; if (framing_error_count !== 16'd1) begin bad++; $display("FAIL gap_errcnt got=%0d exp=1", framing_error_count); end
    total++; if (frame_count !== 32'd1) begin bad++; $display("FAIL gap_frames got=%0d exp=1", frame_count); end
    total++; if (last_frame_len !== 16'd32) begin bad++; $display("FAIL gap_len got=%0d exp=32", last_frame_len); end
    $display("test_ena_gap done");
  endtask

  task automatic test_mty_err();
    clear_counters();
    beat(8'h03, 8'h01, 8'h02, 8'h02, 32'h0000_0003, 1'b1, 1'b0);
    total++; if (framing_error_flags !== 4'b1000) begin bad++; $display("FAIL mty_flags got=%b exp=1000", framing_error_flags); end
    total++; if (last_frame_len !== 16'd32) begin bad++; $display("FAIL mty_len got=%0d exp=32", last_frame_len); end
    total++; if (err_frame_count !== 32'd1) begin bad++; $display("FAIL mty_errframes got=%0d exp=1", err_frame_count); end
    total++; if (byte_count !== 48'd32) begin bad++; $display("FAIL mty_bytes got=%0d exp=32", byte_count); end
    $display("test_mty_err done");
  endtask

  task automatic test_back_to_back();
    clear_counters();
    beat(8'hFF, 8'h55, 8'hAA, 8'h00, 32'h2020_2020, 1'b1, 1'b0);
    total++; if (frame_count !== 32'd4) begin bad++; $display("FAIL b2b_frames got=%0d exp=4", frame_count); end
    total++; if (byte_count !== 48'd120) begin bad++; $display("FAIL b2b_bytes got=%0d exp=120", byte_count); end
    total++; if (last_frame_len !== 16'd30) begin bad++; $display("FAIL b2b_len got=%0d exp=30", last_frame_len); end
    total++; if (runt_count !== 16'd4) begin bad++; $display("FAIL b2b_runts got=%0d exp=4", runt_count); end
    $display("test_back_to_back done");
  endtask

  task automatic test_length_bounds();
    clear_counters();
    beat(8'h0F, 8'h01, 8'h08, 8'h00, 32'h0000_4000, 1'b1, 1'b0);
    total++; if (runt_count !== 16'd0) begin bad++; $display("FAIL min60_runts got=%0d exp=0", runt_count); end
    beat(8'h0F, 8'h01, 8'h08, 8'h00, 32'h0000_5000, 1'b1, 1'b0);
    total++; if (runt_count !== 16'd1) begin bad++; $display("FAIL min59_runts got=%0d exp=1", runt_count); end
    for (int b = 0; b < 75; b++)
      beat(8'hFF, (b == 0) ? 8'h01 : 8'h00, (b == 74) ? 8'h80 : 8'h00, 8'h00, 32'd0, 1'b1, 1'b0);
    total++; if (last_frame_len !== 16'd9600) begin bad++; $display("FAIL max9600_len got=%0d exp=9600", last_frame_len); end
    total++; if (oversize_count !== 16'd0) begin bad++; $display("FAIL max9600_over got=%0d exp=0", oversize_count); end
    for (int b = 0; b < 75; b++)
      beat(8'hFF, (b == 0) ? 8'h01 : 8'h00, 8'h00, 8'h00, 32'd0, 1'b1, 1'b0);
    beat(8'h01, 8'h00, 8'h01, 8'h00, 32'h0000_000F, 1'b1, 1'b0);
    total++; if (last_frame_len !== 16'd9601) begin bad++; $display("FAIL max9601_len got=%0d exp=9601", last_frame_len); end
    total++; if (oversize_count !== 16'd1) begin bad++; $display("FAIL max9601_over got=%0d exp=1", oversize_count); end
    $display("test_length_bounds done");
  endtask

  task automatic test_reset_mid_frame();
    clear_counters();
    beat(8'hFF, 8'h01, 8'h00, 8'h00, 32'd0, 1'b1, 1'b0);
    total++; if (byte_count !== 48'd128) begin bad++; $display("FAIL rstmid_pre_bytes got=%0d exp=128", byte_count); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (byte_count !== 48'd0) begin bad++; $display("FAIL rstmid_bytes got=%0d exp=0", byte_count); end
    @(posedge clk); #1 rst_n = 1'b1;
    beat(8'hFF, 8'h00, 8'h80, 8'h00, 32'd0, 1'b1, 1'b0);
    total++; if (framing_error_flags !== 4'b0100) begin bad++; $display("FAIL rstmid_flags got=%b exp=0100", framing_error_flags); end
    total++; if (frame_count !== 32'd0) begin bad++; $display("FAIL rstmid_frames got=%0d exp=0", frame_count); end
    total++; if (byte_count !== 48'd0) begin bad++; $display("FAIL rstmid_tail_bytes got=%0d exp=0", byte_count); end
    $display("test_reset_mid_frame done");
  endtask

  task automatic test_stall_and_clear();
    clear_counters();
    beat(8'hFF, 8'h01, 8'h00, 8'h00, 32'd0, 1'b0, 1'b0);
    for (int c = 0; c < 9; c++) beat(8'h00, 8'h00, 8'h00, 8'h00, 32'd0, 1'b0, 1'b0);
    total++; if (stall_cycle_count !== 32'd10) begin bad++; $display("FAIL stall_count got=%0d exp=10", stall_cycle_count); end
    total++; if (byte_count !== 48'd128) begin bad++; $display("FAIL stall_bytes got=%0d exp=128", byte_count); end
    beat(8'h01, 8'h00, 8'h01, 8'h00, 32'd0, 1'b1, 1'b1);
    total++; if (frame_count !== 32'd0) begin bad++; $display("FAIL clr_frames got=%0d exp=0", frame_count); end
    total++; if (stall_cycle_count !== 32'd0) begin bad++; $display("FAIL clr_stall got=%0d exp=0", stall_cycle_count); end
    total++; if (byte_count !== 48'd0) begin bad++; $display("FAIL clr_bytes got=%0d exp=0", byte_count); end
    total++; if (last_frame_len_valid !== 1'b0) begin bad++; $display("FAIL clr_valid got=%b exp=0", last_frame_len_valid); end
    total++; if (last_frame_len !== 16'd0) begin bad++; $display("FAIL clr_len got=%0d exp=0", last_frame_len); end
    beat(8'h01, 8'h01, 8'h01, 8'h00, 32'd0, 1'b1, 1'b0);
    total++; if (framing_error_flags !== 4'd0) begin bad++; $display("FAIL postclr_flags got=%b exp=0000", framing_error_flags); end
    total++; if (frame_count !== 32'd1) begin bad++; $display("FAIL postclr_frames got=%0d exp=1", frame_count); end
    total++; if (last_frame_len !== 16'd16) begin bad++; $display("FAIL postclr_len got=%0d exp=16", last_frame_len); end
    $display("test_stall_and_clear done");
  endtask

  initial begin
    rdy = 1'b1; data = '0; ena = 8'd0; sop = 8'd0; eop = 8'd0; err = 8'd0;
    mty = 32'd0; clr = 1'b0; rst_n = 1'b1;
    test_reset();
    test_long_frame();
    test_multi_complete();
    test_sop_in_frame();
    test_ena_gap();
    test_mty_err();
    test_back_to_back();
    test_length_bounds();
    test_reset_mid_frame();
    test_stall_and_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
